// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types and constants for the BCD stopwatch core
package stopwatch_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    CMD_STOP  = 2'd0,
    CMD_HOLD  = 2'd1,
    CMD_CLEAR = 2'd2,
    CMD_RUN   = 2'd3
  } cmd_t;

  typedef enum logic [2:0] {
    S_CLEAR  = 3'd0,
    S_STOP   = 3'd1,
    S_RUN    = 3'd2,
    S_LAP    = 3'd3,
    S_FROZEN = 3'd4
  } state_t;

endpackage

// File: rtl/stopwatch_counter_digit.sv
// rtl/stopwatch_counter_digit.sv - one BCD digit with up/down step, preload and clear
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               step_in,
  input  logic               dir,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_digit,
  input  logic               clear,
  output logic [DIGIT_W-1:0] digit,
  output logic               carry_out
);

  assign carry_out = step_in & (dir ? (digit == 4'd0) : (digit == 4'd9));

  // Preload outranks clear, which outranks a step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= '0;
    end else if (load) begin
      digit <= (load_digit > 4'd9) ? 4'd9 : load_digit;
    end else if (clear) begin
      digit <= '0;
    end else if (step_in) begin
      if (dir) digit <= (digit == 4'd0) ? 4'd9 : digit - 4'd1;
      else     digit <= (digit == 4'd9) ? 4'd0 : digit + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_counter.sv
// rtl/stopwatch_counter.sv - prescaled BCD up/down stopwatch with lap hold and wrap/saturate
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int TICK_PERIOD = 50000,
  parameter int WRAP        = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [1:0]                  cmd,
  input  logic                        dir,
  input  logic                        load,
  input  logic [DIGIT_W*DIGITS-1:0]   load_value,
  output logic [DIGIT_W*DIGITS-1:0]   count_bcd,
  output logic [DIGIT_W*DIGITS-1:0]   display_bcd,
  output logic                        display_en,
  output logic                        tick,
  output logic                        wrapped,
  output logic                        done
);

  localparam int PW = (TICK_PERIOD > 2) ? $clog2(TICK_PERIOD) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_PERIOD - 1);

  cmd_t   cmd_c;
  state_t state, state_nxt;
  logic [PW-1:0] presc;
  logic [DIGIT_W*DIGITS-1:0] hold_q;
  logic [DIGITS:0] carry;
  logic dir_q, dir_chg, run_active, step_raw, step, clear_cnt;
  logic all9, all0, hi9, hi0, at_term, near_term;
  logic block_sat, sat_hit, sat_stop, done_block, held, held_nxt;

  assign cmd_c      = cmd_t'(cmd);
  assign dir_chg    = (dir != dir_q);
  assign run_active = (state == S_RUN) || (state == S_LAP);
  assign step_raw   = run_active && (presc == PRESC_MAX);
  assign clear_cnt  = (cmd_c == CMD_CLEAR);

  always_comb begin
    all9 = 1'b1;
    all0 = 1'b1;
    hi9  = 1'b1;
    hi0  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (count_bcd[i*DIGIT_W +: DIGIT_W] != 4'd9) all9 = 1'b0;
      if (count_bcd[i*DIGIT_W +: DIGIT_W] != 4'd0) all0 = 1'b0;
      if (i > 0 && count_bcd[i*DIGIT_W +: DIGIT_W] != 4'd9) hi9 = 1'b0;
      if (i > 0 && count_bcd[i*DIGIT_W +: DIGIT_W] != 4'd0) hi0 = 1'b0;
    end
  end

  assign at_term   = dir ? all0 : all9;
  assign near_term = dir ? (hi0 && count_bcd[3:0] == 4'd1) : (hi9 && count_bcd[3:0] == 4'd8);

  // In saturate mode a step from the terminal value never happens
  assign block_sat  = (WRAP == 0) && at_term && step_raw;
  assign step       = step_raw && !load && !clear_cnt && !block_sat;
  assign sat_hit    = (WRAP == 0) && step && near_term;
  assign sat_stop   = sat_hit || (block_sat && !load);
  assign done_block = done && !load && !dir_chg;

  assign carry[0] = step;
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk        (clk),
      .rst_n      (rst_n),
      .step_in    (carry[g]),
      .dir        (dir),
      .load       (load),
      .load_digit (load_value[g*DIGIT_W +: DIGIT_W]),
      .clear      (clear_cnt),
      .digit      (count_bcd[g*DIGIT_W +: DIGIT_W]),
      .carry_out  (carry[g+1])
    );
  end

  always_comb begin
    state_nxt = state;
    case (cmd_c)
      CMD_CLEAR: state_nxt = S_CLEAR;
      CMD_STOP:  state_nxt = S_STOP;
      CMD_RUN:   state_nxt = done_block ? state : S_RUN;
      CMD_HOLD: begin
        if (state == S_RUN) state_nxt = S_LAP;
        else if (state == S_STOP || state == S_CLEAR) state_nxt = S_FROZEN;
      end
      default:   state_nxt = state;
    endcase
    if (sat_stop && cmd_c != CMD_CLEAR) state_nxt = S_STOP;
  end

  assign held     = (state == S_LAP) || (state == S_FROZEN);
  assign held_nxt = (state_nxt == S_LAP) || (state_nxt == S_FROZEN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_CLEAR;
      presc   <= '0;
      hold_q  <= '0;
      dir_q   <= 1'b0;
      tick    <= 1'b0;
      wrapped <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      dir_q   <= dir;
      tick    <= step;
      wrapped <= (WRAP != 0) ? (step && carry[DIGITS]) : sat_hit;
      if (state == S_CLEAR || load) presc <= '0;
      else if (run_active) presc <= (presc == PRESC_MAX) ? '0 : presc + 1'b1;
      if (held_nxt && !held) hold_q <= count_bcd;
      if (clear_cnt || state == S_CLEAR || load || dir_chg) done <= 1'b0;
      else if (sat_stop) done <= 1'b1;
    end
  end

  assign display_bcd = held ? hold_q : count_bcd;
  assign display_en  = (state != S_CLEAR);

endmodule
